// File: rtl/mux_share_arb.sv
// Round-robin arbiter for two requesters sharing one W-bit output channel, with bounded bursts.
// Optional MUX_ARB_LOCK_EN adds a LOCK input that suppresses preemption for atomic transfers.
module mux_share_arb #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
`ifdef MUX_ARB_LOCK_EN
  input  logic         LOCK,
`endif
  output logic         GNT0,
  output logic         GNT1,
  output logic         S,
  output logic [W-1:0] OUT,
  output logic         OUT_VALID
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t       state_reg, state_next;
  logic         last_reg, last_next;
  logic [7:0]   cnt_reg, cnt_next;
  logic [W-1:0] out_reg;
  logic         out_valid_reg;
  logic         own_port;
  logic         req_own;
  logic         req_oth;
  logic         lock_hold;
  logic         word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    own_port   = (state_reg == G1);
    req_own    = own_port ? REQ1 : REQ0;
    req_oth    = own_port ? REQ0 : REQ1;
`ifdef MUX_ARB_LOCK_EN
    lock_hold  = LOCK;
`else
    lock_hold  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        // On a tie, last_reg==1 means port 1 was served last, so port 0 wins.
        if (REQ0 && (!REQ1 || last_reg))
          state_next = G0;
        else if (REQ1)
          state_next = G1;
      end
      G0, G1: begin
        if (!req_own) begin
          state_next = req_oth ? (own_port ? G0 : G1) : IDLE;
          last_next  = own_port;
          cnt_next   = 8'd0;
        end else if (lock_hold) begin
          cnt_next = (cnt_reg == HOLD_LAST) ? cnt_reg : cnt_reg + 8'd1;
        end else if (cnt_reg == HOLD_LAST) begin
          // Burst limit reached: hand over if contended, otherwise start a fresh burst.
          if (req_oth) begin
            state_next = own_port ? G0 : G1;
            last_next  = own_port;
          end
          cnt_next = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign word = (GNT0 & REQ0) | (GNT1 & REQ1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= word;
      if (word)
        out_reg <= S ? I1 : I0;
    end
  end

  assign GNT0      = (state_reg == G0);
  assign GNT1      = (state_reg == G1);
  assign S         = GNT1;
  assign OUT       = out_reg;
  assign OUT_VALID = out_valid_reg;

endmodule

// File: tb/tb_mux_share_arb.sv
// Directed self-checking bench for mux_share_arb (W=8, MAX_HOLD=4).
// LOCK scenario runs only when MUX_ARB_LOCK_EN is defined.
module tb_mux_share_arb;

  logic       clk;
  logic       rst_n;
  logic       REQ0, REQ1;
  logic [7:0] I0, I1;
`ifdef MUX_ARB_LOCK_EN
  logic       LOCK;
`endif
  logic       GNT0, GNT1, S, OUT_VALID;
  logic [7:0] OUT;

  int total = 0;
  int bad   = 0;

  mux_share_arb #(.W(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .REQ0      (REQ0),
    .REQ1      (REQ1),
    .I0        (I0),
    .I1        (I1),
`ifdef MUX_ARB_LOCK_EN
    .LOCK      (LOCK),
`endif
    .GNT0      (GNT0),
    .GNT1      (GNT1),
    .S         (S),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pat;

  initial begin
    rst_n = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; I0 = 8'h00; I1 = 8'h00;
`ifdef MUX_ARB_LOCK_EN
    LOCK = 1'b0;
`endif
    // Reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      REQ0 = 1'($urandom); REQ1 = 1'($urandom);
      I0 = 8'($urandom); I1 = 8'($urandom);
      tick();
      check_val("rst_gnt0", 32'(GNT0), 32'd0);
      check_val("rst_gnt1", 32'(GNT1), 32'd0);
      check_val("rst_s", 32'(S), 32'd0);
      check_val("rst_out", 32'(OUT), 32'd0);
      check_val("rst_valid", 32'(OUT_VALID), 32'd0);
    end

    // Release with both requesting: port 0 wins the first tie
    rst_n = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; I0 = 8'hA5; I1 = 8'h5A;
    tick();
    check_val("rel_gnt0", 32'(GNT0), 32'd1);
    check_val("rel_gnt1", 32'(GNT1), 32'd0);
    check_val("rel_valid0", 32'(OUT_VALID), 32'd0);
    tick();
    check_val("rel_valid1", 32'(OUT_VALID), 32'd1);
    check_val("rel_out", 32'(OUT), 32'hA5);
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    check_val("rel_idle_gnt0", 32'(GNT0), 32'd0);
    check_val("rel_idle_valid", 32'(OUT_VALID), 32'd0);
    check_val("rel_out_hold", 32'(OUT), 32'hA5);

    // Single requester: unbounded burst, data 0..9
    REQ1 = 1'b1; I1 = 8'h00;
    tick();
    check_val("single_gnt1", 32'(GNT1), 32'd1);
    check_val("single_s", 32'(S), 32'd1);
    for (int i = 0; i < 10; i++) begin
      I1 = 8'(i);
      tick();
      check_val("single_gnt1_hold", 32'(GNT1), 32'd1);
      check_val("single_valid", 32'(OUT_VALID), 32'd1);
      check_val("single_out", 32'(OUT), 32'(i));
    end
    REQ1 = 1'b0;
    tick();
    check_val("single_end_valid", 32'(OUT_VALID), 32'd0);
    check_val("single_end_gnt1", 32'(GNT1), 32'd0);
    check_val("single_end_out", 32'(OUT), 32'd9);

    // Contention: port 1 served last, so port 0 first; 4 words per turn
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    pat = 16'hF0F0;
    for (int c = 0; c < 16; c++) begin
      I0 = 8'(8'h40 + c);
      I1 = 8'(8'h80 + c);
      check_val("cont_gnt1", 32'(GNT1), 32'(pat[c]));
      check_val("cont_gnt0", 32'(GNT0), 32'(!pat[c]));
      tick();
      check_val("cont_valid", 32'(OUT_VALID), 32'd1);
      check_val("cont_out", 32'(OUT), pat[c] ? 32'(8'h80 + c) : 32'(8'h40 + c));
    end

    // Early release: two words from port 0, then drop REQ0
    for (int c = 16; c < 18; c++) begin
      I0 = 8'(8'hC0 + c);
      check_val("early_gnt0", 32'(GNT0), 32'd1);
      tick();
      check_val("early_out", 32'(OUT), 32'(8'hC0 + c));
    end
    REQ0 = 1'b0;
    check_val("early_gnt0_drop", 32'(GNT0), 32'd1);
    tick();
    check_val("early_gap_valid", 32'(OUT_VALID), 32'd0);
    check_val("early_gnt1", 32'(GNT1), 32'd1);
    // Fresh count: port 1 keeps 4 full words before preemption
    REQ0 = 1'b1;
    for (int c = 19; c < 23; c++) begin
      I1 = 8'(8'hD0 + c);
      check_val("early_g1_hold", 32'(GNT1), 32'd1);
      tick();
      check_val("early_g1_out", 32'(OUT), 32'(8'hD0 + c));
    end
    check_val("early_back_gnt0", 32'(GNT0), 32'd1);

    // Reset mid-burst in G1
    REQ0 = 1'b0;
    tick();
    check_val("mid_gnt1", 32'(GNT1), 32'd1);
    I1 = 8'hEE;
    tick();
    check_val("mid_valid", 32'(OUT_VALID), 32'd1);
    check_val("mid_out", 32'(OUT), 32'hEE);
    #3 rst_n = 1'b0;
    #1;
    check_val("mid_rst_gnt1", 32'(GNT1), 32'd0);
    check_val("mid_rst_s", 32'(S), 32'd0);
    check_val("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    check_val("mid_rst_out", 32'(OUT), 32'd0);
    tick();
    rst_n = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; I0 = 8'h3C;
    tick();
    check_val("mid_rel_gnt0", 32'(GNT0), 32'd1);
    check_val("mid_rel_gnt1", 32'(GNT1), 32'd0);

`ifdef MUX_ARB_LOCK_EN
    // LOCK keeps port 0 for 10 words despite contention
    LOCK = 1'b1;
    for (int c = 0; c < 10; c++) begin
      I0 = 8'(8'h60 + c);
      check_val("lock_gnt0", 32'(GNT0), 32'd1);
      tick();
      check_val("lock_out", 32'(OUT), 32'(8'h60 + c));
      check_val("lock_valid", 32'(OUT_VALID), 32'd1);
    end
    LOCK = 1'b0;
    tick();
    check_val("unlock_gnt1", 32'(GNT1), 32'd1);
`else
    // Without LOCK the post-reset burst is cut after 4 words
    for (int c = 0; c < 4; c++) begin
      I0 = 8'(8'h60 + c);
      check_val("post_gnt0", 32'(GNT0), 32'd1);
      tick();
      check_val("post_out", 32'(OUT), 32'(8'h60 + c));
    end
    check_val("post_gnt1", 32'(GNT1), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_share_arb.md
# mux_share_arb

Round-robin arbiter and sequencer for the shared 2:1 mux datapath. Two requesters contend for one W-bit output channel. The block grants one requester at a time, limits each grant to a bounded burst, and drives the mux select `S`. It also registers the selected data onto `OUT`/`OUT_VALID` for the downstream consumer.

## Interface
- `W`, default 8: data width of each input and of `OUT`.
- `MAX_HOLD`, default 4: maximum consecutive data cycles per grant while the other side is requesting; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `REQ0` input 1: requester 0 wants the channel; held high while it has data.
- `REQ1` input 1: requester 1 wants the channel.
- `I0` input W: requester 0 data; sampled only in a cycle where `GNT0 & REQ0`.
- `I1` input W: requester 1 data; sampled only in a cycle where `GNT1 & REQ1`.
- `GNT0` output 1: registered grant to requester 0.
- `GNT1` output 1: registered grant to requester 1.
- `S` output 1: mux select; equals `GNT1`.
- `OUT` output W: registered selected data.
- `OUT_VALID` output 1: `OUT` holds a new word this cycle.
- `LOCK` input 1: present only with `MUX_ARB_LOCK_EN`; see Configuration.

## Operation
- States are IDLE, G0 and G1. `GNT0` = (state==G0) and `GNT1` = (state==G1); they are never high together.
- Register `last` holds the last served port. Reset value is 1, so port 0 wins the first tie.
- Hold counter `cnt` is 8 bits. It counts data cycles of the current grant and is cleared on every state change.
- IDLE:
  - Only REQ0 high: go to G0.
  - Only REQ1 high: go to G1.
  - Both high: go to the port that is not `last`.
  - Neither high: stay in IDLE.
- Gn, where m is the other port, in priority order:
  1. REQn low: go to Gm if REQm is high, else go to IDLE. Set `last`=n.
  2. REQn high, cnt==MAX_HOLD-1 and REQm high: go to Gm. Set `last`=n. This preemption takes effect after the MAX_HOLD-th data cycle.
  3. REQn high, cnt==MAX_HOLD-1 and REQm low: stay in Gn and clear cnt. The burst continues unbounded.
  4. Otherwise: stay in Gn and increment cnt.
- Datapath:
  - Each cycle, `OUT_VALID` <= `(GNT0&REQ0)|(GNT1&REQ1)`.
  - When that term is 1, `OUT` <= `S ? I1 : I0`. Otherwise `OUT` holds its value.
- No word is ever dropped or duplicated. Each cycle with `GNTn&REQn` high produces exactly one `OUT_VALID` pulse one cycle later.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state=IDLE, `GNT0`=`GNT1`=`S`=0, `OUT`=0, `OUT_VALID`=0, cnt=0, `last`=1.
- Request-to-grant latency:
  - From IDLE, REQ rising in cycle t gives GNT high in cycle t+1.
  - A switch from Gn to Gm takes 0 idle cycles: GNTn drops and GNTm rises on the same edge.
- Data latency: `I0`/`I1` sampled at edge t+1 appears on `OUT` with `OUT_VALID` during cycle t+1.
- REQn deasserted while GNTn is high: that cycle produces no data, and the grant is released at the next edge.
- Simultaneous REQ0/REQ1 rise from IDLE: the port that is not `last` wins.
- MAX_HOLD=1 gives strict alternation under contention.
- `rst_n` asserted mid-burst: all outputs clear immediately. After release, the first tie goes to port 0.

## Configuration
- `MUX_ARB_LOCK_EN` defined:
  - Adds input `LOCK`.
  - While in Gn with REQn and LOCK both high, the preemption rule (rule 2) is suppressed and cnt saturates at MAX_HOLD-1. The current owner keeps the channel for an atomic transfer.
  - Releasing LOCK with the other port requesting gives a switch at the next edge.
- `MUX_ARB_LOCK_EN` undefined: there is no `LOCK` port, and preemption always applies.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. All outputs are 0. Release with REQ0=REQ1=1, I0=8'hA5: GNT0=1 one cycle later, then OUT=8'hA5 with OUT_VALID=1.
- Single requester: REQ1=1 for 10 cycles with I1 incrementing 0..9. GNT1 stays high throughout with no preemption. OUT shows 0..9 on consecutive cycles, and OUT_VALID is low the cycle after REQ1 falls.
- Contention, MAX_HOLD=4: REQ0 and REQ1 continuously high. GNT pattern is 0,0,0,0,1,1,1,1,0…. Exactly 4 OUT_VALID words per port per turn, with no gap cycles.
- Early release: in G0 with REQ1 high, drop REQ0 after 2 words. GNT1 rises on the next edge and cnt restarts at 0.
- Reset mid-burst: assert `rst_n`=0 asynchronously during G1. GNT1, S and OUT_VALID go to 0 before the next clock edge. After release with both requesting, port 0 is granted.
- `MUX_ARB_LOCK_EN`: in G0 with LOCK=1 and REQ1=1, hold for 10 cycles. GNT0 holds for all 10 words. Drop LOCK: GNT1 is high on the following cycle.
